// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word widths, IR field layout, opcodes and the
// fetch state encoding used by the fetch stage.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 16;

  // IR field bit positions
  localparam int OPER_TYPE_HI = 31;
  localparam int OPER_TYPE_LO = 27;
  localparam int RDST_HI      = 26;
  localparam int RDST_LO      = 22;
  localparam int RSRC1_HI     = 21;
  localparam int RSRC1_LO     = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_HI     = 15;
  localparam int RSRC2_LO     = 11;
  localparam int ISRC_HI      = 15;
  localparam int ISRC_LO      = 0;

  // 5-bit operation codes carried in oper_type
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b00001;
  localparam logic [4:0] OP_STORE = 5'b00010;
  localparam logic [4:0] OP_ADD   = 5'b00011;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_XOR   = 5'b00111;
  localparam logic [4:0] OP_SHL   = 5'b01000;
  localparam logic [4:0] OP_SHR   = 5'b01001;
  localparam logic [4:0] OP_JMP   = 5'b01010;
  localparam logic [4:0] OP_BEQ   = 5'b01011;

  // Fetch FSM: FETCH means one memory read is in flight
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fetch_state_t;

  // Extract the operation code from an instruction word
  function automatic logic [4:0] ir_oper_type(input logic [INSTR_W-1:0] ir);
    return ir[OPER_TYPE_HI:OPER_TYPE_LO];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH x W synchronous FIFO with flush. Flush wins over a
// simultaneous push; the head is read straight from the storage registers.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 48,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle synchronous
// instruction memory, buffers responses in a prefetch queue and presents
// them to execute.
//
// Handshake: ir_valid/ir_data/ir_pc come from the queue head. A transfer
// happens on a rising edge where ir_valid & ir_ready are both high; while
// ir_valid is high and no transfer happens, ir_data/ir_pc hold steady.
module instr_fetch_unit #(
  parameter int PC_W    = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W,
  parameter int DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  output logic                  imem_en,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [INSTR_W-1:0]    imem_rdata,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [INSTR_W-1:0]    ir_data,
  output logic [PC_W-1:0]       ir_pc,
  input  logic                  redirect,
  input  logic [PC_W-1:0]       redirect_pc,
  output logic                  busy,
  output cpu_pkg::fetch_state_t dbg_state
);

  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t            state;
  logic [PC_W-1:0]         pc;
  logic [PC_W-1:0]         tag;
  logic [CNT_W-1:0]        count;
  logic [CNT_W:0]          occupancy;
  logic [PC_W+INSTR_W-1:0] head;
  logic                    inflight;
  logic                    pop;
  logic                    push;
  logic                    kill;
  logic                    issue;

  assign inflight = (state == ST_FETCH);
  assign ir_valid = (count != '0);
  assign pop      = ir_valid & ir_ready;

  // Slots committed after this edge: a same-cycle pop frees its slot, which
  // is what lets a 2-entry queue sustain one instruction per cycle.
  assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);

  // No strobe while held in reset, so the memory never sees a stray read.
  assign issue = rst_n & run & ~redirect & (occupancy < (CNT_W+1)'(DEPTH));

  // A redirect discards the response landing in the same cycle.
  assign kill = redirect & inflight;
  assign push = inflight & ~kill;

  assign imem_en   = issue;
  assign imem_addr = pc;
  assign busy      = ir_valid | inflight;
  assign dbg_state = state;
  assign {ir_pc, ir_data} = head;

  // PC, in-flight tag and IDLE/FETCH tracking of the outstanding read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= '0;
      tag   <= '0;
    end else begin
      state <= issue ? ST_FETCH : ST_IDLE;
      if (issue) tag <= pc;
      if (redirect)   pc <= redirect_pc;
      else if (issue) pc <= pc + 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (PC_W + INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({tag, imem_rdata}),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of expected
// {pc, word} deliveries and cycle-level checks of the fetch timing.
module tb_instr_fetch_unit;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 2;
  localparam int E_W     = PC_W + INSTR_W;

  logic                  clk;
  logic                  rst_n;
  logic                  run;
  logic                  imem_en;
  logic [PC_W-1:0]       imem_addr;
  logic [INSTR_W-1:0]    imem_rdata;
  logic                  ir_valid;
  logic                  ir_ready;
  logic [INSTR_W-1:0]    ir_data;
  logic [PC_W-1:0]       ir_pc;
  logic                  redirect;
  logic [PC_W-1:0]       redirect_pc;
  logic                  busy;
  cpu_pkg::fetch_state_t dbg_state;

  logic [E_W-1:0] exp_q[$];
  int total;
  int bad;

  instr_fetch_unit #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_en     (imem_en),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [INSTR_W-1:0] mem_word(input logic [PC_W-1:0] a);
    return 32'h1000_0000 + {16'h0000, a};
  endfunction

  // instruction memory: data appears one cycle after the strobe
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [E_W-1:0] obs, input logic [E_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [PC_W-1:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  // scoreboard: every handshake must match the next expected delivery
  always @(negedge clk) begin
    if (rst_n && ir_valid && ir_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", {ir_pc, ir_data}, '0);
      end else begin
        check("delivery", {ir_pc, ir_data}, exp_q.pop_front());
      end
    end
  end

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_issue(input string tag, input logic en, input logic [PC_W-1:0] addr);
    check({tag, "_en"}, E_W'(imem_en), E_W'(en));
    if (en) check({tag, "_addr"}, E_W'(imem_addr), E_W'(addr));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_falls"}, E_W'(busy), '0);
    check({tag, "_all_delivered"}, E_W'(exp_q.size()), '0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    run = 1'b0;
    ir_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_rdata = '0;

    // reset state
    #2;
    check("rst_imem_en", E_W'(imem_en), '0);
    check("rst_imem_addr", E_W'(imem_addr), '0);
    check("rst_ir_valid", E_W'(ir_valid), '0);
    check("rst_ir_data", E_W'(ir_data), '0);
    check("rst_ir_pc", E_W'(ir_pc), '0);
    check("rst_busy", E_W'(busy), '0);
    check("rst_state", E_W'(dbg_state), E_W'(cpu_pkg::ST_IDLE));
    tick();
    rst_n = 1'b1;

    // 1: streaming, one word per cycle after a 2-cycle latency
    for (int i = 0; i < 10; i++) expect_word(PC_W'(i));
    tick();
    run = 1'b1;
    ir_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      @(negedge clk);
      check_issue("t1_issue", 1'b1, PC_W'(i));
      if (i < 2) check("t1_latency_valid", E_W'(ir_valid), '0);
      else       check("t1_nogap_valid", E_W'(ir_valid), 1);
      if (i == 1) check("t1_state_fetch", E_W'(dbg_state), E_W'(cpu_pkg::ST_FETCH));
    end
    tick();
    run = 1'b0;
    wait_idle("t1");
    check("t1_state_idle", E_W'(dbg_state), E_W'(cpu_pkg::ST_IDLE));

    // 2: backpressure fills the queue, head stays stable, then drains in order
    for (int a = 10; a < 16; a++) expect_word(PC_W'(a));
    tick();
    run = 1'b1;
    ir_ready = 1'b0;
    @(negedge clk);
    check_issue("t2_c0", 1'b1, 16'd10);
    tick();
    @(negedge clk);
    check_issue("t2_c1", 1'b1, 16'd11);
    for (int c = 2; c < 6; c++) begin
      tick();
      @(negedge clk);
      check_issue("t2_full_stall", 1'b0, '0);
      check("t2_head_valid", E_W'(ir_valid), 1);
      check("t2_head_pc", E_W'(ir_pc), E_W'(16'd10));
      check("t2_head_data", E_W'(ir_data), E_W'(mem_word(16'd10)));
    end
    tick();
    ir_ready = 1'b1;
    @(negedge clk);
    check_issue("t2_resume", 1'b1, 16'd12);
    for (int a = 13; a < 16; a++) begin
      tick();
      @(negedge clk);
      check_issue("t2_stream", 1'b1, PC_W'(a));
    end
    tick();
    run = 1'b0;
    wait_idle("t2");

    // 3: redirect with a read in flight and the head being popped
    expect_word(16'd16);
    for (int a = 'h40; a < 'h43; a++) expect_word(PC_W'(a));
    tick();
    run = 1'b1;
    @(negedge clk);
    check_issue("t3_s0", 1'b1, 16'd16);
    tick();
    @(negedge clk);
    check_issue("t3_s1", 1'b1, 16'd17);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    check_issue("t3_redirect_noissue", 1'b0, '0);
    check("t3_redirect_head", E_W'(ir_pc), E_W'(16'd16));
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check_issue("t3_new_pc", 1'b1, 16'h0040);
    check("t3_flushed", E_W'(ir_valid), '0);
    tick();
    @(negedge clk);
    check_issue("t3_next", 1'b1, 16'h0041);
    check("t3_stale_dropped", E_W'(ir_valid), '0);
    tick();
    @(negedge clk);
    check("t3_first_valid", E_W'(ir_valid), 1);
    check("t3_first_pc", E_W'(ir_pc), E_W'(16'h0040));
    tick();
    run = 1'b0;
    wait_idle("t3");

    // 4: PC wraps from FFFF to 0000
    expect_word(16'hFFFE);
    expect_word(16'hFFFF);
    expect_word(16'h0000);
    expect_word(16'h0001);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    run = 1'b1;
    @(negedge clk);
    check_issue("t4_redirect", 1'b0, '0);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check_issue("t4_a", 1'b1, 16'hFFFE);
    tick();
    @(negedge clk);
    check_issue("t4_b", 1'b1, 16'hFFFF);
    tick();
    @(negedge clk);
    check_issue("t4_wrap", 1'b1, 16'h0000);
    tick();
    @(negedge clk);
    check_issue("t4_d", 1'b1, 16'h0001);
    tick();
    run = 1'b0;
    wait_idle("t4");

    // 5: stop after issuing address 5, then resume at 6
    expect_word(16'd3);
    expect_word(16'd4);
    expect_word(16'd5);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'd3;
    run = 1'b1;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check_issue("t5_a3", 1'b1, 16'd3);
    tick();
    tick();
    @(negedge clk);
    check_issue("t5_a5", 1'b1, 16'd5);
    tick();
    run = 1'b0;
    @(negedge clk);
    check_issue("t5_stopped", 1'b0, '0);
    check("t5_busy_inflight", E_W'(busy), 1);
    tick();
    @(negedge clk);
    check_issue("t5_still_stopped", 1'b0, '0);
    wait_idle("t5");
    expect_word(16'd6);
    tick();
    run = 1'b1;
    @(negedge clk);
    check_issue("t5_resume", 1'b1, 16'd6);
    tick();
    run = 1'b0;
    wait_idle("t5b");

    // 6: asynchronous reset mid-stream; stale response ignored
    tick();
    redirect = 1'b1;
    redirect_pc = 16'd7;
    tick();
    redirect = 1'b0;
    run = 1'b1;
    @(negedge clk);
    check_issue("t6_a7", 1'b1, 16'd7);
    tick();
    @(negedge clk);
    check_issue("t6_a8", 1'b1, 16'd8);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_en", E_W'(imem_en), '0);
    check("t6_rst_addr", E_W'(imem_addr), '0);
    check("t6_rst_valid", E_W'(ir_valid), '0);
    check("t6_rst_data", E_W'(ir_data), '0);
    check("t6_rst_pc", E_W'(ir_pc), '0);
    check("t6_rst_busy", E_W'(busy), '0);
    expect_word(16'd0);
    expect_word(16'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_issue("t6_restart0", 1'b1, 16'd0);
    check("t6_restart_valid", E_W'(ir_valid), '0);
    tick();
    @(negedge clk);
    check_issue("t6_restart1", 1'b1, 16'd1);
    check("t6_stale_ignored", E_W'(ir_valid), '0);
    tick();
    run = 1'b0;
    @(negedge clk);
    check("t6_first_pc", E_W'(ir_pc), '0);
    wait_idle("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
